// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU datapath: float field widths, converter
// state encoding and status bit positions.
package fpu_pkg;

  localparam int BIAS  = 31;
  localparam int EXP_W = 6;
  localparam int MAN_W = 25;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2
  } cvt_state_t;

  localparam int ST_ZERO    = 0;
  localparam int ST_INEXACT = 1;
  localparam int ST_NEG     = 2;

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even on a normalized mantissa; a carry out of the
// mantissa renormalizes by bumping the exponent.
module fp_round_rne
  import fpu_pkg::*;
#(
  parameter int MW = MAN_W,
  parameter int EW = EXP_W
) (
  input  logic [MW-1:0] man,
  input  logic          guard,
  input  logic          sticky,
  input  logic [EW-1:0] exp,
  output logic [MW-1:0] man_rnd,
  output logic [EW-1:0] exp_rnd
);

  logic          inc;
  logic [MW:0]   sum;

  // Ties go up only when the kept LSB is odd.
  assign inc = guard & (sticky | man[0]);
  assign sum = {1'b0, man} + (MW+1)'(inc);

  // On carry the low bits of sum are already zero: 1.111..1 + ulp = 10.000..0.
  assign man_rnd = sum[MW-1:0];
  assign exp_rnd = exp + EW'(sum[MW]);

endmodule

// File: rtl/int_to_fp.sv
// Serial int32 -> float converter: one normalizing left shift per cycle,
// then a single round-to-nearest-even step.
module int_to_fp
  import fpu_pkg::*;
#(
  parameter int BIAS  = fpu_pkg::BIAS,
  parameter int EXP_W = fpu_pkg::EXP_W,
  parameter int MAN_W = fpu_pkg::MAN_W
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] int_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] data_out,
  output logic [3:0]  status_out
);

  cvt_state_t       state_q, state_d;
  logic             sign_q, sign_d;
  logic [31:0]      mag_q, mag_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  logic [31:0]      data_d;
  logic [3:0]       status_d;
  logic             done_d;

  logic [31:0]      int_abs;
  logic             guard, sticky;
  logic [MAN_W-1:0] man_rnd;
  logic [EXP_W-1:0] exp_rnd;

  // Unsigned negate: 0x80000000 maps to 2^31 as required.
  assign int_abs = int_in[31] ? (~int_in + 32'd1) : int_in;

  assign guard  = mag_q[30-MAN_W];
  assign sticky = |mag_q[29-MAN_W:0];

  fp_round_rne #(.MW(MAN_W), .EW(EXP_W)) u_round (
    .man     (mag_q[30 -: MAN_W]),
    .guard   (guard),
    .sticky  (sticky),
    .exp     (exp_q),
    .man_rnd (man_rnd),
    .exp_rnd (exp_rnd)
  );

  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    state_d  = state_q;
    sign_d   = sign_q;
    mag_d    = mag_q;
    exp_d    = exp_q;
    data_d   = data_out;
    status_d = status_out;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (int_in == 32'd0) begin
            data_d   = 32'd0;
            status_d = 4'b0001 << ST_ZERO;
            done_d   = 1'b1;
          end else begin
            sign_d  = int_in[31];
            mag_d   = int_abs;
            exp_d   = EXP_W'(31 + BIAS);
            state_d = NORM;
          end
        end
      end
      NORM: begin
        if (mag_q[31]) begin
          state_d = ROUND;
        end else begin
          mag_d = mag_q << 1;
          exp_d = exp_q - EXP_W'(1);
        end
      end
      ROUND: begin
        data_d                 = {sign_q, exp_rnd, man_rnd};
        status_d               = 4'b0000;
        status_d[ST_NEG]       = sign_q;
        status_d[ST_INEXACT]   = guard | sticky;
        done_d                 = 1'b1;
        state_d                = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed above.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      sign_q     <= 1'b0;
      mag_q      <= 32'd0;
      exp_q      <= '0;
      data_out   <= 32'd0;
      status_out <= 4'd0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      sign_q     <= sign_d;
      mag_q      <= mag_d;
      exp_q      <= exp_d;
      data_out   <= data_d;
      status_out <= status_d;
      done       <= done_d;
    end
  end

  assign busy = (state_q != IDLE);

endmodule
